// File: rtl/i2s_codec_link_if.sv
// Signal bundle between the I2S codec link and its sample/codec side.
// The master view belongs to the link; the slave view to whatever feeds and consumes it.
interface i2s_codec_link_if;
  logic [15:0] sample_in;
  logic        iAUD_ADCDAT;
  logic        oAUD_BCK;
  logic        oAUD_LRCK;
  logic        oAUD_ADCLRCK;
  logic        oAUD_DATA;
  logic [15:0] sample_out;
  logic        sample_valid;

  modport master (
    input  sample_in, iAUD_ADCDAT,
    output oAUD_BCK, oAUD_LRCK, oAUD_ADCLRCK, oAUD_DATA, sample_out, sample_valid
  );

  modport slave (
    output sample_in, iAUD_ADCDAT,
    input  oAUD_BCK, oAUD_LRCK, oAUD_ADCLRCK, oAUD_DATA, sample_out, sample_valid
  );
endinterface

// File: rtl/i2s_codec_link.sv
// I2S master link: generates BCK/LRCK, serialises a 16-bit DAC word per frame and
// captures the left-channel 16-bit ADC word; all outputs come straight from registers.
module i2s_codec_link #(
  parameter int BCK_HALF = 3,
  parameter bit DAC_DUP  = 1'b1
) (
  input  logic              clk18,
  input  logic              reset_n,
  i2s_codec_link_if.master  bus
);
  localparam logic [3:0] DIV_LAST = 4'(BCK_HALF - 1);

  logic [3:0]  div_reg;
  logic        bck_reg;
  logic [5:0]  bitcnt_reg;
  logic [15:0] word_reg;
  logic [15:0] shift_reg;
  logic [15:0] out_reg;
  logic        data_reg;
  logic        valid_reg;

  logic        tick;
  logic        fall_evt;
  logic        rise_evt;
  logic [5:0]  bitcnt_next;
  logic [4:0]  slot_next;
  logic [3:0]  bit_idx;
  logic [15:0] word_next;
  logic        data_next;
  logic        adc_slot;

  always_comb begin
    tick        = (div_reg == DIV_LAST);
    fall_evt    = tick && bck_reg;
    rise_evt    = tick && !bck_reg;
    bitcnt_next = bitcnt_reg + 6'd1;
    // The new word is latched on the wrap and is the one the whole next frame uses.
    word_next   = (bitcnt_reg == 6'd63) ? bus.sample_in : word_reg;
    slot_next   = bitcnt_next[4:0];
    bit_idx     = 4'(5'd16 - slot_next);
    data_next   = 1'b0;
    if ((slot_next >= 5'd1) && (slot_next <= 5'd16) && (!bitcnt_next[5] || DAC_DUP))
      data_next = word_next[bit_idx];
    adc_slot    = !bitcnt_reg[5] && (bitcnt_reg[4:0] >= 5'd1) && (bitcnt_reg[4:0] <= 5'd16);
  end

  always_ff @(posedge clk18) begin
    if (!reset_n) begin
      div_reg    <= '0;
      bck_reg    <= 1'b0;
      bitcnt_reg <= '0;
      word_reg   <= '0;
      shift_reg  <= '0;
      out_reg    <= '0;
      data_reg   <= 1'b0;
      valid_reg  <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      if (tick) begin
        div_reg <= '0;
        bck_reg <= ~bck_reg;
      end else begin
        div_reg <= div_reg + 4'd1;
      end
      if (fall_evt) begin
        bitcnt_reg <= bitcnt_next;
        word_reg   <= word_next;
        data_reg   <= data_next;
        if (bitcnt_reg == 6'd31) begin
          out_reg   <= shift_reg;
          valid_reg <= 1'b1;
        end
      end
      // ADC data is sampled mid-bit, on the rising BCK edge, left slots only.
      if (rise_evt && adc_slot)
        shift_reg <= {shift_reg[14:0], bus.iAUD_ADCDAT};
    end
  end

  assign bus.oAUD_BCK     = bck_reg;
  assign bus.oAUD_LRCK    = bitcnt_reg[5];
  assign bus.oAUD_ADCLRCK = bitcnt_reg[5];
  assign bus.oAUD_DATA    = data_reg;
  assign bus.sample_out   = out_reg;
  assign bus.sample_valid = valid_reg;
endmodule

// File: tb/tb_i2s_codec_link.sv
// Directed bench for i2s_codec_link: one default instance (BCK_HALF=3, DAC_DUP=1)
// and one swept instance (BCK_HALF=2, DAC_DUP=0), each with a small codec model.
module tb_i2s_codec_link;
  logic clk18 = 1'b0;
  always #5 clk18 = ~clk18;

  logic [1:0]  rst_n;
  logic [15:0] s_in [2];

  i2s_codec_link_if bus_a();
  i2s_codec_link_if bus_b();

  i2s_codec_link #(.BCK_HALF(3), .DAC_DUP(1'b1)) u_a (.clk18(clk18), .reset_n(rst_n[0]), .bus(bus_a));
  i2s_codec_link #(.BCK_HALF(2), .DAC_DUP(1'b0)) u_b (.clk18(clk18), .reset_n(rst_n[1]), .bus(bus_b));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  logic [1:0]  bck, lrck, adclrck, data, valid;
  logic [15:0] sout [2];
  assign bck     = {bus_b.oAUD_BCK,     bus_a.oAUD_BCK};
  assign lrck    = {bus_b.oAUD_LRCK,    bus_a.oAUD_LRCK};
  assign adclrck = {bus_b.oAUD_ADCLRCK, bus_a.oAUD_ADCLRCK};
  assign data    = {bus_b.oAUD_DATA,    bus_a.oAUD_DATA};
  assign valid   = {bus_b.sample_valid, bus_a.sample_valid};
  assign sout[0] = bus_a.sample_out;
  assign sout[1] = bus_b.sample_out;
  assign bus_a.sample_in = s_in[0];
  assign bus_b.sample_in = s_in[1];

  // Observed frame position per instance, advanced on every BCK fall seen on the pins.
  logic [5:0]  pos [2]         = '{6'd0, 6'd0};
  logic        pbck [2]        = '{1'b0, 1'b0};
  logic        plrck [2]       = '{1'b0, 1'b0};
  logic        pvalid [2]      = '{1'b0, 1'b0};
  logic [63:0] cur_frame [2];
  logic [63:0] frame_log [2][4];
  int          frames_done [2] = '{0, 0};
  int          valid_cnt [2]   = '{0, 0};
  int          consec [2]      = '{0, 0};
  int          bad_time [2]    = '{0, 0};
  int          lr_mism [2]     = '{0, 0};
  int          lr_pos_mism [2] = '{0, 0};

  // Codec ADC model: 8001 MSB-first in left slots 1..16, ones through the right half.
  function automatic logic adc_bit(input logic [5:0] p);
    logic [15:0] w;
    logic [4:0]  s;
    w = 16'h8001;
    s = p[4:0];
    if (p[5]) return 1'b1;
    if (s >= 5'd1 && s <= 5'd16) return w[4'(5'd16 - s)];
    return 1'b0;
  endfunction

  assign bus_a.iAUD_ADCDAT = adc_bit(pos[0]);
  assign bus_b.iAUD_ADCDAT = adc_bit(pos[1]);

  function automatic logic exp_lrck(input logic [5:0] p, input logic fell);
    logic [5:0] q;
    q = fell ? p + 6'd1 : p;
    return q[5];
  endfunction

  function automatic logic [15:0] slot_word(input logic [63:0] f, input int base);
    logic [15:0] w;
    for (int i = 0; i < 16; i++) w[15-i] = f[base+1+i];
    return w;
  endfunction

  function automatic logic [15:0] pad_bits(input logic [63:0] f, input int base);
    logic [15:0] w;
    w[15] = f[base];
    for (int i = 0; i < 15; i++) w[i] = f[base+17+i];
    return w;
  endfunction

  always @(negedge clk18) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n[d]) begin
        pos[d]         <= '0;
        pbck[d]        <= 1'b0;
        plrck[d]       <= 1'b0;
        pvalid[d]      <= 1'b0;
        frames_done[d] <= 0;
      end else begin
        pbck[d]   <= bck[d];
        plrck[d]  <= lrck[d];
        pvalid[d] <= valid[d];
        if (adclrck[d] !== lrck[d]) lr_mism[d] <= lr_mism[d] + 1;
        if (lrck[d] !== exp_lrck(pos[d], pbck[d] && !bck[d])) lr_pos_mism[d] <= lr_pos_mism[d] + 1;
        if (!pbck[d] && bck[d]) cur_frame[d][pos[d]] <= data[d];
        if (pbck[d] && !bck[d]) begin
          pos[d] <= pos[d] + 6'd1;
          if (pos[d] == 6'd63) begin
            if (frames_done[d] < 4) frame_log[d][frames_done[d]] <= cur_frame[d];
            frames_done[d] <= frames_done[d] + 1;
          end
        end
        if (valid[d]) begin
          valid_cnt[d] <= valid_cnt[d] + 1;
          if (pvalid[d]) consec[d] <= consec[d] + 1;
          if (!(lrck[d] && !plrck[d])) bad_time[d] <= bad_time[d] + 1;
          chk($sformatf("adc_word_%0d", d), 64'(sout[d]), 64'h8001);
        end
      end
    end
  end

  // Hold the selected resets low across 'cycles' rising edges; inputs change 2 ns after an edge.
  task automatic do_reset(input logic [1:0] which, input int cycles);
    @(posedge clk18); #2;
    rst_n = rst_n & ~which;
    repeat (cycles) @(posedge clk18);
    #2;
    rst_n = rst_n | which;
  endtask

  task automatic wait_frames(input int d, input int n, input int budget);
    int c;
    c = 0;
    while (frames_done[d] < n && c < budget) begin
      @(negedge clk18);
      c++;
    end
    chk($sformatf("frames_reached_%0d", d), 64'(frames_done[d] >= n), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got time limit reached, expected self-termination");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t_r1 [2];
    int   t_r2 [2];
    int   t_f1 [2];
    int   t_up [2];
    int   t_dn [2];
    int   e_r1 [2] = '{3, 2};
    int   e_r2 [2] = '{9, 6};
    int   e_f1 [2] = '{6, 4};
    int   e_up [2] = '{192, 128};
    int   e_dn [2] = '{384, 256};
    logic pb [2];
    logic pl [2];
    int   v0;
    int   c;

    rst_n   = 2'b00;
    s_in[0] = 16'hA5C3;
    s_in[1] = 16'hA5C3;

    // Reset state and clock timing after release.
    do_reset(2'b11, 2);
    @(negedge clk18);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_outputs_%0d", d),
          64'({bck[d], lrck[d], adclrck[d], data[d], valid[d], sout[d]}), 64'd0);
      t_r1[d] = -1; t_r2[d] = -1; t_f1[d] = -1; t_up[d] = -1; t_dn[d] = -1;
      pb[d] = bck[d]; pl[d] = lrck[d];
    end
    for (int t = 1; t <= 400; t++) begin
      @(negedge clk18);
      for (int d = 0; d < 2; d++) begin
        if (!pb[d] && bck[d]) begin
          if (t_r1[d] < 0) t_r1[d] = t;
          else if (t_r2[d] < 0) t_r2[d] = t;
        end
        if (pb[d] && !bck[d] && t_f1[d] < 0) t_f1[d] = t;
        if (!pl[d] && lrck[d] && t_up[d] < 0) t_up[d] = t;
        if (pl[d] && !lrck[d] && t_dn[d] < 0) t_dn[d] = t;
        pb[d] = bck[d];
        pl[d] = lrck[d];
      end
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("bck_first_rise_%0d", d),  64'(t_r1[d]), 64'(e_r1[d]));
      chk($sformatf("bck_second_rise_%0d", d), 64'(t_r2[d]), 64'(e_r2[d]));
      chk($sformatf("bck_first_fall_%0d", d),  64'(t_f1[d]), 64'(e_f1[d]));
      chk($sformatf("lrck_rise_%0d", d),       64'(t_up[d]), 64'(e_up[d]));
      chk($sformatf("lrck_fall_%0d", d),       64'(t_dn[d]), 64'(e_dn[d]));
    end

    // DAC serialisation of A5C3 and ADC capture, swept instance first (shorter frame).
    wait_frames(1, 2, 1000);
    chk("b_frame1_zero",   frame_log[1][0], 64'd0);
    chk("b_left_word",     64'(slot_word(frame_log[1][1], 0)),  64'hA5C3);
    chk("b_left_pad",      64'(pad_bits(frame_log[1][1], 0)),   64'h0);
    chk("b_right_word",    64'(slot_word(frame_log[1][1], 32)), 64'h0);
    chk("b_right_pad",     64'(pad_bits(frame_log[1][1], 32)),  64'h0);
    chk("b_valid_count",   64'(valid_cnt[1]), 64'd2);
    wait_frames(0, 2, 1000);
    chk("a_frame1_zero",   frame_log[0][0], 64'd0);
    chk("a_left_word",     64'(slot_word(frame_log[0][1], 0)),  64'hA5C3);
    chk("a_left_pad",      64'(pad_bits(frame_log[0][1], 0)),   64'h0);
    chk("a_right_word",    64'(slot_word(frame_log[0][1], 32)), 64'hA5C3);
    chk("a_right_pad",     64'(pad_bits(frame_log[0][1], 32)),  64'h0);
    chk("a_valid_count",   64'(valid_cnt[0]), 64'd2);

    // Mid-frame sample_in change at bitcnt 8 of the 1234 frame.
    s_in[0] = 16'h1234;
    do_reset(2'b11, 2);
    wait_frames(0, 1, 500);
    c = 0;
    while (pos[0] != 6'd8 && c < 100) begin
      @(negedge clk18);
      c++;
    end
    chk("a_pos8_reached", 64'(pos[0]), 64'd8);
    @(posedge clk18); #2;
    s_in[0] = 16'h0F0F;
    wait_frames(0, 3, 1500);
    chk("a_chg_cur_left",   64'(slot_word(frame_log[0][1], 0)),  64'h1234);
    chk("a_chg_cur_right",  64'(slot_word(frame_log[0][1], 32)), 64'h1234);
    chk("a_chg_next_left",  64'(slot_word(frame_log[0][2], 0)),  64'h0F0F);
    chk("a_chg_next_right", 64'(slot_word(frame_log[0][2], 32)), 64'h0F0F);

    // One-cycle reset at bitcnt 20, then restart timing.
    c = 0;
    while (pos[0] != 6'd20 && c < 400) begin
      @(negedge clk18);
      c++;
    end
    chk("a_pos20_reached", 64'(pos[0]), 64'd20);
    v0 = valid_cnt[0];
    do_reset(2'b01, 1);
    @(negedge clk18);
    chk("a_midreset_outputs",
        64'({bck[0], lrck[0], adclrck[0], data[0], valid[0], sout[0]}), 64'd0);
    t_r1[0] = -1; t_f1[0] = -1; pb[0] = bck[0];
    for (int t = 1; t <= 100; t++) begin
      @(negedge clk18);
      if (!pb[0] && bck[0] && t_r1[0] < 0) t_r1[0] = t;
      if (pb[0] && !bck[0] && t_f1[0] < 0) t_f1[0] = t;
      pb[0] = bck[0];
    end
    chk("a_restart_rise", 64'(t_r1[0]), 64'd3);
    chk("a_restart_fall", 64'(t_f1[0]), 64'd6);
    chk("a_no_valid_after_reset", 64'(valid_cnt[0] - v0), 64'd0);

    for (int d = 0; d < 2; d++) begin
      chk($sformatf("valid_consecutive_%0d", d), 64'(consec[d]),      64'd0);
      chk($sformatf("valid_timing_%0d", d),      64'(bad_time[d]),    64'd0);
      chk($sformatf("adclrck_equal_%0d", d),     64'(lr_mism[d]),     64'd0);
      chk($sformatf("lrck_vs_bitpos_%0d", d),    64'(lr_pos_mism[d]), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
